// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive engine: FSM states,
// receive-entry layout and the parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int ENTRY_W  = 10;
  localparam int DATA_LSB = 0;
  localparam int PERR_BIT = 8;
  localparam int FERR_BIT = 9;

  // Expected parity bit over 7 or 8 data bits (bit 7 ignored in 7-bit mode).
  function automatic logic parity_calc(input logic [7:0] d, input logic eight, input logic even);
    logic [7:0] m;
    m = eight ? d : {1'b0, d[6:0]};
    return even ? ^m : ~^m;
  endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Bus-side register interface of the UART receive engine: head-of-FIFO
// character, its error flags, occupancy and the pop strobe.
interface uart_rx_engine_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          reads;
  logic          rx_rdy;
  logic [7:0]    data;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;
  logic [CW-1:0] count;

  modport master (input reads, output rx_rdy, data, parity_err, frame_err, overflow, count);
  modport slave  (output reads, input rx_rdy, data, parity_err, frame_err, overflow, count);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head; a pop and
// a push may share a cycle even when full.
module uart_rx_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] count_d;
  logic [W-1:0]  head_d;
  logic          push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // The head register must already hold whatever becomes the front entry.
  always_comb begin
    count_d = count + CW'(push_ok) - CW'(pop_ok);
    rd_next = rd_ptr + AW'(pop_ok);
    head_d  = mem[rd_next];
    if (count_d == '0)
      head_d = '0;
    else if (push_ok && (count == CW'(pop_ok)))
      head_d = din;
  end

  // NOTE: storage array has no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_d;
      head   <= head_d;
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: rx synchroniser, mid-bit start validation, 7/8-bit
// framing with optional parity, and per-character error tagging.
// Build option: UART_RX_FIFO_EN selects the DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int KW          = 19,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic [KW-1:0] k,
  input  logic          eight,
  input  logic          p_en,
  input  logic          even,
  uart_rx_engine_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_d;

  assign rxs = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_d  <= rxs;
    end
  end

  rx_state_e     state_q, state_d;
  logic [KW-1:0] k_l, cnt;
  logic          eight_l, p_en_l, even_l;
  logic [3:0]    bit_idx, n_bits;
  logic [8:0]    sh;
  logic          load, cnt_clr, shift_en, push;
  logic          half_hit, bit_hit, last_bit;

  assign half_hit = (cnt == (k_l >> 1) - KW'(1));
  assign bit_hit  = (cnt == k_l - KW'(1));
  assign n_bits   = 4'd7 + {3'b0, eight_l} + {3'b0, p_en_l};
  assign last_bit = (bit_idx == n_bits - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path infers a latch.
    state_d  = state_q;
    load     = 1'b0;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      IDLE:  if (rxs_d && !rxs && (k >= KW'(4))) begin
               load    = 1'b1;
               state_d = START;
             end
      START: if (half_hit) begin
               cnt_clr = 1'b1;
               state_d = rxs ? IDLE : DATA;
             end
      DATA:  if (bit_hit) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (last_bit) state_d = STOP;
             end
      STOP:  if (bit_hit) begin
               cnt_clr = 1'b1;
               push    = 1'b1;
               state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
  end

  // Frame settings are frozen at the start edge so mid-frame changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_l     <= '0;
      eight_l <= 1'b0;
      p_en_l  <= 1'b0;
      even_l  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else if (load) begin
      k_l     <= k;
      eight_l <= eight;
      p_en_l  <= p_en;
      even_l  <= even;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + KW'(1);
      if (shift_en) begin
        sh[bit_idx] <= rxs;
        bit_idx     <= bit_idx + 4'd1;
      end
    end
  end

  logic [7:0]         rx_data;
  logic               pbit, perr, ferr;
  logic [ENTRY_W-1:0] entry;

  assign rx_data = eight_l ? sh[7:0] : {1'b0, sh[6:0]};
  assign pbit    = eight_l ? sh[8] : sh[7];
  assign perr    = p_en_l & (pbit != parity_calc(rx_data, eight_l, even_l));
  assign ferr    = ~rxs;

  always_comb begin
    entry                   = '0;
    entry[DATA_LSB +: 8]    = rx_data;
    entry[PERR_BIT]         = perr;
    entry[FERR_BIT]         = ferr;
  end

  logic [ENTRY_W-1:0] head;
  logic [CW-1:0]      occ;
  logic               rdy, full, pop_ok, drop, overflow_q;

`ifdef UART_RX_FIFO_EN
  logic empty;

  uart_rx_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (entry),
    .pop   (bus.reads),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  assign rdy = ~empty;
`else
  logic               hold_v;
  logic [ENTRY_W-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v <= 1'b0;
      hold_q <= '0;
    end else if (push && (!hold_v || bus.reads)) begin
      hold_v <= 1'b1;
      hold_q <= entry;
    end else if (bus.reads && hold_v) begin
      hold_v <= 1'b0;
      hold_q <= '0;
    end
  end

  assign head = hold_q;
  assign rdy  = hold_v;
  assign full = hold_v;
  assign occ  = CW'(hold_v);
`endif

  // A push into a full buffer survives only if the head is popped in the same cycle.
  assign pop_ok = bus.reads & rdy;
  assign drop   = push & full & ~bus.reads;

  always_ff @(posedge clk) begin
    if (rst)         overflow_q <= 1'b0;
    else if (pop_ok) overflow_q <= 1'b0;
    else if (drop)   overflow_q <= 1'b1;
  end

  assign bus.rx_rdy     = rdy;
  assign bus.data       = head[DATA_LSB +: 8];
  assign bus.parity_err = head[PERR_BIT];
  assign bus.frame_err  = head[FERR_BIT];
  assign bus.overflow   = overflow_q;
  assign bus.count      = occ;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: framing, parity/frame errors, false start,
// buffer overflow and mid-frame reset, with hand-computed expectations.
module tb_uart_rx_engine;

  localparam int K = 16;
`ifdef UART_RX_FIFO_EN
  localparam int EFF_DEPTH = 16;
`else
  localparam int EFF_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [18:0] k;
  logic        eight, p_en, even;
  int          total = 0;
  int          bad   = 0;
  int          lat;

  uart_rx_engine_if #(.DEPTH(16)) bus ();

  uart_rx_engine #(
    .KW          (19),
    .DEPTH       (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .k     (k),
    .eight (eight),
    .p_en  (p_en),
    .even  (even),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (K) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nd, input bit has_p,
                            input logic pb, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < nd; i++) send_bit(d[i]);
    if (has_p) send_bit(pb);
    send_bit(stop_v);
    rx = 1'b1;
  endtask

  task automatic do_pop();
    bus.reads = 1'b1;
    @(negedge clk);
    bus.reads = 1'b0;
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    rx        = 1'b1;
    k         = 19'(K);
    eight     = 1'b1;
    p_en      = 1'b0;
    even      = 1'b0;
    bus.reads = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_rdy",  bus.rx_rdy, 0);
    check("rst_data", bus.data, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovf",  bus.overflow, 0);
    check("rst_cnt",  bus.count, 0);
    repeat (5) @(negedge clk);

    // 8N1 0x55: sync (3) + half bit (8) + 9 bit times (144) = 155 cycles.
    fork
      send_frame(8'h55, 8, 0, 1'b0, 1'b1);
      begin
        lat = 0;
        while (!bus.rx_rdy && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("55_lat",  lat, 155);
    check("55_rdy",  bus.rx_rdy, 1);
    check("55_data", bus.data, 8'h55);
    check("55_perr", bus.parity_err, 0);
    check("55_ferr", bus.frame_err, 0);
    check("55_cnt",  bus.count, 1);
    do_pop();
    check("55_pop_rdy", bus.rx_rdy, 0);
    check("55_pop_cnt", bus.count, 0);
    repeat (8) @(negedge clk);

    // 7E1 0x41: two ones, correct even parity is 0; send 1.
    eight = 1'b0; p_en = 1'b1; even = 1'b1;
    send_frame(8'h41, 7, 1, 1'b1, 1'b1);
    check("7e1_rdy",  bus.rx_rdy, 1);
    check("7e1_data", bus.data, 8'h41);
    check("7e1_perr", bus.parity_err, 1);
    check("7e1_ferr", bus.frame_err, 0);
    do_pop();

    // 8O1 0x5A: four ones, correct odd parity is 1.
    eight = 1'b1; p_en = 1'b1; even = 1'b0;
    send_frame(8'h5A, 8, 1, 1'b1, 1'b1);
    check("8o1_data", bus.data, 8'h5A);
    check("8o1_perr", bus.parity_err, 0);
    do_pop();
    eight = 1'b1; p_en = 1'b0; even = 1'b0;
    repeat (8) @(negedge clk);

    // Stop bit forced low.
    send_frame(8'hA3, 8, 0, 1'b0, 1'b0);
    check("fe_data", bus.data, 8'hA3);
    check("fe_ferr", bus.frame_err, 1);
    check("fe_perr", bus.parity_err, 0);
    do_pop();
    repeat (K) @(negedge clk);

    // Five-cycle glitch must be rejected at the mid-start sample.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_cnt", bus.count, 0);
    check("glitch_rdy", bus.rx_rdy, 0);

    // EFF_DEPTH+1 back-to-back characters, no reads: last one dropped.
    for (int i = 0; i < EFF_DEPTH + 1; i++) send_frame(8'(i), 8, 0, 1'b0, 1'b1);
    check("ovf_cnt", bus.count, EFF_DEPTH);
    check("ovf_set", bus.overflow, 1);
    for (int i = 0; i < EFF_DEPTH; i++) begin
      check($sformatf("ovf_rd%0d", i), bus.data, i);
      do_pop();
      if (i == 0) check("ovf_clr", bus.overflow, 0);
    end
    check("ovf_empty", bus.rx_rdy, 0);
    repeat (8) @(negedge clk);

    // Same again, but a read lands in the cycle of the final push.
    for (int i = 0; i < EFF_DEPTH; i++) send_frame(8'(i), 8, 0, 1'b0, 1'b1);
    fork
      send_frame(8'(EFF_DEPTH), 8, 0, 1'b0, 1'b1);
      begin
        repeat (154) @(negedge clk);
        bus.reads = 1'b1;
        @(negedge clk);
        bus.reads = 1'b0;
      end
    join
    check("rdp_ovf", bus.overflow, 0);
    check("rdp_cnt", bus.count, EFF_DEPTH);
    for (int i = 0; i < EFF_DEPTH; i++) begin
      check($sformatf("rdp_rd%0d", i), bus.data, i + 1);
      do_pop();
    end
    check("rdp_empty", bus.rx_rdy, 0);
    repeat (8) @(negedge clk);

    // Reset in the middle of a data bit with a character already buffered.
    send_frame(8'h99, 8, 0, 1'b0, 1'b1);
    check("pre_rst_cnt", bus.count, 1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy",  bus.rx_rdy, 0);
    check("mid_rst_data", bus.data, 0);
    check("mid_rst_cnt",  bus.count, 0);
    check("mid_rst_flag", {bus.parity_err, bus.frame_err, bus.overflow}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h3C, 8, 0, 1'b0, 1'b1);
    check("post_rst_data", bus.data, 8'h3C);
    check("post_rst_cnt",  bus.count, 1);
    check("post_rst_flag", {bus.parity_err, bus.frame_err}, 0);
    do_pop();
    check("post_rst_empty", bus.rx_rdy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Parametrised next-generation UART receive engine: synchronises the serial `rx` line, validates the start bit at mid-bit, shifts 7/8 data bits plus optional parity and one stop bit, and pushes each character with its own error flags into a first-word-fall-through receive FIFO. It sits between the pad-side `rx` input and the bus-side register interface. It replaces the separate control/datapath pair with one block that adds per-character error tagging, FIFO buffering, configurable divisor width and false-start rejection.

## Interface
- `KW`, 19: bit-time divisor width.
- `DEPTH`, 16: receive FIFO depth; power of two, at least 2.
- `SYNC_STAGES`, 2: `rx` synchroniser flops; at least 2.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial line, idle high.
- `k` in KW: clocks per bit time.
- `eight` in 1: 1 = 8 data bits, 0 = 7 data bits.
- `p_en` in 1: parity bit present.
- `even` in 1: 1 = even parity, 0 = odd parity.
- `reads` in 1: single-cycle pop of the FIFO head.
- `rx_rdy` out 1: FIFO not empty.
- `data` out 8: head character; bit 7 is 0 in 7-bit mode.
- `parity_err` out 1: parity error flag of the head entry.
- `frame_err` out 1: frame error flag of the head entry.
- `overflow` out 1: sticky flag; a character was dropped.
- `count` out $clog2(DEPTH+1): FIFO occupancy.

## Operation
- Synchronised `rx` is `rxs`.
- States: IDLE, START, DATA, STOP.
- IDLE: a 1-to-0 transition on `rxs` latches `k`, `eight`, `p_en` and `even` into frame registers, clears the bit-time counter, and moves to START. If `k` < 4, the block stays in IDLE.
- START: wait `k>>1` cycles, then sample `rxs`.
  - Sample 1: false start; return to IDLE and push nothing.
  - Sample 0: go to DATA.
- DATA: sample every latched-`k` cycles, shifting LSB-first. Takes `7+eight+p_en` samples; the parity bit is the last sample when enabled. Then go to STOP.
- STOP: one sample after `k` cycles.
  - `frame_err` = sample is 0.
  - `parity_err` = p_en & (pbit != (even ? ^data : ~^data)), evaluated over the 7 or 8 data bits.
  - Push {frame_err, parity_err, data} and return to IDLE in the same cycle. No wait for the stop-bit end, so back-to-back frames resync.
- FIFO:
  - Push when full and `reads` low: the character is dropped and `overflow` sets.
  - Push when full and `reads` high: both operations occur and no overflow.
  - `reads` while empty is ignored.
  - `overflow` clears on any accepted `reads`, or on reset.
- `rst` mid-frame aborts the frame, empties the FIFO and clears all flags.

## Timing
- Reset values: IDLE, `rx_rdy`=0, `data`=0, `parity_err`=0, `frame_err`=0, `overflow`=0, `count`=0. Synchroniser flops reset to 1.
- `rx` edge to FSM detection: SYNC_STAGES+1 cycles.
- Stop sample cycle N gives `rx_rdy`, `data` and flags valid at N+1.
- Head outputs are registered. A pop at cycle N presents the next entry, or `rx_rdy`=0, at N+1.
- `count` updates one cycle after push or pop, and is unchanged on a simultaneous push and pop.
- Changes to `k` or mode inputs mid-frame have no effect until the next start.

## Configuration
- `UART_RX_FIFO_EN` defined: DEPTH-entry FIFO as described.
- `UART_RX_FIFO_EN` undefined: the FIFO is replaced by a single holding register (effective depth 1). `count` is 0 or 1.
  - A push while `rx_rdy`=1 and `reads`=0 drops the character and sets `overflow`.
  - All other timing is identical.

## Structure
- Package `uart_pkg` holds:
  - the state enum;
  - `ENTRY_W`=10 and the field offsets `DATA_LSB`=0, `PERR_BIT`=8, `FERR_BIT`=9;
  - function `parity_calc(data, eight, even)`.
- One sub-module, `uart_rx_fifo`: a parametrised sync FWFT FIFO (width ENTRY_W, depth DEPTH) with a registered head.

## Test plan
Bench uses k=16, 8 data bits, no parity (8N1) unless stated.
- 8N1, send 0x55 -> `rx_rdy` rises one cycle after the stop sample, about 8+9×16 cycles after synchronised start detect. `data`=0x55, no flags. `reads` gives `rx_rdy`=0 next cycle.
- 7E1 (`eight`=0, `p_en`=1, `even`=1), send 0x41 with a wrong parity bit -> `data`=0x41, `parity_err`=1, `frame_err`=0.
- 8N1, stop bit forced 0 on 0xA3 -> `data`=0xA3, `frame_err`=1.
- Low glitch of 5 cycles on idle `rx` -> no push, FSM returns to IDLE, `count`=0.
- DEPTH+1 back-to-back characters 0x00..0x10 with no reads -> `count`=DEPTH and `overflow`=1. Entries 0x00..0x0F are read in order; one read clears `overflow`. Repeat with `reads` asserted in the 17th push cycle -> no overflow.
- `rst` asserted during a data bit -> all outputs at reset values next cycle; the next clean 0x3C is received correctly.
